top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 177 +++++++++++++++++
 tb/tb_top.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Wishbone-mapped LWE ciphertext ALU: element-wise ADD/SUB/COPY mod q over DIMENSION+1 words.
// Define OPENENCLAVE_IRQ_EN to pulse user_irq[0] for one cycle when an operation completes.
module top #(
  parameter int          PLAINTEXT_MODULUS  = 64,
  parameter int          PLAINTEXT_WIDTH    = 6,
  parameter int          CIPHERTEXT_MODULUS = 1024,
  parameter int          CIPHERTEXT_WIDTH   = 10,
  parameter int          DIMENSION          = 2,
  parameter int          BIG_N              = 2,
  parameter logic [31:0] OPCODE_ADDR        = 32'h3000_0000,
  parameter logic [31:0] OUTPUT_ADDR        = 32'h1000_0000,
  parameter int          DATA_WIDTH         = 128,
  parameter int          ADDR_WIDTH         = 10,
  parameter int          DEPTH              = 1024,
  parameter int          DIM_WIDTH          = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic [127:0]  la_data_in,
  output logic [127:0]  la_data_out,
  input  logic [127:0]  la_oenb,
  input  logic [37:0]   io_in,
  output logic [37:0]   io_out,
  output logic [37:0]   io_oeb,
  inout  wire  [28:0]   analog_io,
  input  logic          user_clock2,
  output logic [2:0]    user_irq
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_COPY = 2'b10, OP_NOP = 2'b11} op_e;

  localparam logic [CIPHERTEXT_WIDTH:0] MOD_Q = (CIPHERTEXT_WIDTH+1)'(CIPHERTEXT_MODULUS);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [ADDR_WIDTH-1:0]  a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
  logic [DIM_WIDTH-1:0]   idx_q, idx_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;

  logic                   wb_req, is_opc, busy;
  logic [ADDR_WIDTH-1:0]  wb_idx, a_addr, b_addr;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [CIPHERTEXT_WIDTH-1:0] a_val, b_val, res;
  logic [CIPHERTEXT_WIDTH:0]   wide;

  assign wb_req = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign is_opc = (wbs_adr_i == OPCODE_ADDR);
  assign busy   = (state_q != S_IDLE);
  assign wb_idx = wbs_adr_i[ADDR_WIDTH-1:0];
  assign a_addr = a_base_q + ADDR_WIDTH'(idx_q);
  assign b_addr = b_base_q + ADDR_WIDTH'(idx_q);

  // Operands are < q, so one conditional correction keeps results in [0, q).
  always_comb begin
    a_val = mem[a_addr][CIPHERTEXT_WIDTH-1:0];
    b_val = mem[b_addr][CIPHERTEXT_WIDTH-1:0];
    wide  = '0;
    res   = '0;
    case (op_q)
      OP_ADD: begin
        wide = {1'b0, a_val} + {1'b0, b_val};
        if (wide >= MOD_Q) wide = wide - MOD_Q;
        res = wide[CIPHERTEXT_WIDTH-1:0];
      end
      OP_SUB: begin
        if (a_val >= b_val) wide = {1'b0, a_val} - {1'b0, b_val};
        else                wide = {1'b0, a_val} + MOD_Q - {1'b0, b_val};
        res = wide[CIPHERTEXT_WIDTH-1:0];
      end
      default: res = a_val;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    d_base_d  = d_base_q;
    idx_d     = idx_q;
    ack_d     = wb_req;
    dat_d     = dat_q;
    mem_we    = 1'b0;
    mem_waddr = wb_idx;
    mem_wdata = DATA_WIDTH'(wbs_dat_i);

    if (wb_req) begin
      if (wbs_we_i) begin
        if (is_opc) begin
          if (!busy) begin
            op_d     = op_e'(wbs_dat_i[1:0]);
            a_base_d = ADDR_WIDTH'(wbs_dat_i[11:2]);
            b_base_d = ADDR_WIDTH'(wbs_dat_i[21:12]);
            d_base_d = ADDR_WIDTH'(wbs_dat_i[31:22]);
            idx_d    = '0;
            state_d  = (op_e'(wbs_dat_i[1:0]) == OP_NOP) ? S_DONE : S_RUN;
          end
        end else if (!busy) begin
          mem_we = 1'b1;
        end
      end else begin
        dat_d = is_opc ? {31'b0, busy} : mem[wb_idx][31:0];
      end
    end

    case (state_q)
      S_RUN: begin
        mem_we    = 1'b1;
        mem_waddr = d_base_q + ADDR_WIDTH'(idx_q);
        mem_wdata = DATA_WIDTH'(res);
        if (idx_q == DIM_WIDTH'(DIMENSION)) state_d = S_DONE;
        else                                idx_d   = idx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      a_base_q <= '0;
      b_base_q <= '0;
      d_base_q <= '0;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      d_base_q <= d_base_d;
      idx_q    <= idx_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign la_data_out = {127'b0, busy};
  assign io_out      = '0;
  assign io_oeb      = '1;

`ifdef OPENENCLAVE_IRQ_EN
  assign user_irq = {2'b00, state_q == S_DONE};
`else
  assign user_irq = '0;
`endif

  logic        unused_inputs;
  logic [31:0] unused_params;
  assign unused_inputs = ^{wbs_sel_i, la_data_in, la_oenb, io_in, analog_io, user_clock2};
  assign unused_params = 32'(PLAINTEXT_MODULUS) ^ 32'(PLAINTEXT_WIDTH) ^ 32'(BIG_N) ^ OUTPUT_ADDR;

endmodule

// File: tb/tb_top.sv
// Randomised bench for top: Wishbone memory/opcode traffic checked against a behavioural memory model.
module tb_top;
  localparam int          Q    = 1024;
  localparam int          NEL  = 3;
  localparam logic [31:0] OPC  = 32'h3000_0000;
`ifdef OPENENCLAVE_IRQ_EN
  localparam int          EXP_IRQ = 1;
`else
  localparam int          EXP_IRQ = 0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = 4'hf;
  logic [31:0]  adr = '0, wdat = '0;
  logic         ack;
  logic [31:0]  rdat;
  logic [127:0] la_in = '0, la_oenb = '0, la_out;
  logic [37:0]  io_in = '0, io_out, io_oeb;
  wire  [28:0]  analog_io;
  logic [2:0]   user_irq;

  top dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_data_in(la_in), .la_data_out(la_out), .la_oenb(la_oenb),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .analog_io(analog_io), .user_clock2(1'b0), .user_irq(user_irq)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] model_mem   [Q];
  bit          model_valid [Q];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] op_word(input logic [1:0] op, input logic [9:0] a,
                                          input logic [9:0] b, input logic [9:0] d);
    return {d, b, a, op};
  endfunction

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    logic got = 1'b0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    check("ack", {127'b0, got}, 128'd1);
    r = rdat;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, r);
  endtask

  task automatic mem_write(input int idx, input logic [31:0] v);
    wb_write(32'(idx), v);
    model_mem[idx]   = v;
    model_valid[idx] = 1'b1;
  endtask

  task automatic wait_idle();
    logic [31:0] s = 32'h1;
    for (int n = 0; n < 20 && s != 0; n++) wb_read(OPC, s);
    check("idle", s, 0);
  endtask

  // Elements are processed in order, so later elements observe earlier results when ranges overlap.
  task automatic run_model(input int op, input int a, input int b, input int d);
    for (int i = 0; i < NEL; i++) begin
      int unsigned av = model_mem[(a + i) % Q] % Q;
      int unsigned bv = model_mem[(b + i) % Q] % Q;
      int unsigned r;
      if (op == 3) return;
      case (op)
        0:       r = (av + bv) % Q;
        1:       r = (av + Q - bv) % Q;
        default: r = av;
      endcase
      model_mem[(d + i) % Q]   = r;
      model_valid[(d + i) % Q] = 1'b1;
    end
  endtask

  task automatic do_op(input int op, input int a, input int b, input int d);
    wb_write(OPC, op_word(op[1:0], a[9:0], b[9:0], d[9:0]));
    wait_idle();
    run_model(op, a, b, d);
  endtask

  task automatic check_dest(input string tag, input int d);
    logic [31:0] r;
    for (int i = 0; i < NEL; i++) begin
      if (model_valid[(d + i) % Q]) begin
        wb_read(32'((d + i) % Q), r);
        check(tag, r, model_mem[(d + i) % Q]);
      end
    end
  endtask

  task automatic load_src(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2);
    mem_write(0, a0);   mem_write(1, a1);   mem_write(2, a2);
    mem_write(100, b0); mem_write(101, b1); mem_write(102, b2);
  endtask

  initial begin
    logic [31:0] r;
    int          irq_cnt;
    for (int i = 0; i < Q; i++) begin model_mem[i] = '0; model_valid[i] = 1'b0; end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {127'b0, ack}, 0);
    check("rst_dat", rdat, 0);
    check("rst_busy", la_out, 0);
    check("rst_irq", user_irq, 0);
    @(negedge clk); rst = 1'b0;

    // Plain add
    load_src(10, 15, 20, 20, 25, 30);
    do_op(0, 0, 100, 50);
    wb_read(50, r); check("add0", r, 30);
    wb_read(51, r); check("add1", r, 40);
    wb_read(52, r); check("add2", r, 50);

    // Subtract wrapping below zero, add wrapping above q
    load_src(5, 0, 0, 10, 0, 0);
    do_op(1, 0, 100, 60);
    wb_read(60, r); check("sub_wrap", r, 1019);
    load_src(1000, 0, 0, 30, 0, 0);
    do_op(0, 0, 100, 70);
    wb_read(70, r); check("add_wrap", r, 6);

    // Status reads busy mid-run, then idle
    wb_write(OPC, op_word(2'd0, 10'd0, 10'd100, 10'd80));
    wb_read(OPC, r); check("status_run", r, 1);
    wait_idle();
    run_model(0, 0, 100, 80);
    check_dest("status_dest", 80);

    // Opcode held for 5 cycles runs once; dest overlaps A so a second run would show
    load_src(10, 15, 20, 20, 25, 30);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = OPC; wdat = op_word(2'd0, 10'd0, 10'd100, 10'd0);
    irq_cnt = 0;
    for (int e = 0; e < 7; e++) begin
      @(posedge clk); #1;
      if (user_irq[0]) irq_cnt++;
      if (e == 0) check("busy_run", la_out, 1);
      if (e == 4) begin
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("busy_idle", la_out, 0);
      end
    end
    check("irq_pulses", irq_cnt, EXP_IRQ);
    check("irq_hi_bits", user_irq[2:1], 0);
    run_model(0, 0, 100, 0);
    wb_read(0, r); check("held0", r, 30);
    wb_read(1, r); check("held1", r, 40);
    wb_read(2, r); check("held2", r, 50);

    // Memory and opcode writes while busy are ignored
    mem_write(400, 32'h1234);
    wb_write(OPC, op_word(2'd2, 10'd0, 10'd100, 10'd500));
    wb_write(32'd400, 32'hdead);
    wb_write(OPC, op_word(2'd2, 10'd0, 10'd100, 10'd400));
    wait_idle();
    run_model(2, 0, 100, 500);
    wb_read(400, r); check("busy_wr_ignored", r, 32'h1234);
    check_dest("busy_copy", 500);

    // NOP leaves memory alone
    mem_write(300, 77);
    do_op(3, 0, 100, 300);
    wb_read(300, r); check("nop", r, 77);

    // Base wrap across the top of memory
    mem_write(1022, $urandom); mem_write(1023, $urandom); mem_write(0, $urandom);
    mem_write(200, $urandom);  mem_write(201, $urandom);  mem_write(202, $urandom);
    do_op(0, 1022, 200, 1022);
    check_dest("base_wrap", 1022);

    // Reset mid-run: first element already committed, the rest untouched
    load_src(1, 2, 3, 4, 5, 6);
    mem_write(600, 32'h111); mem_write(601, 32'h222); mem_write(602, 32'h333);
    wb_read(600, r);
    wb_write(OPC, op_word(2'd0, 10'd0, 10'd100, 10'd600));
    #1 rst = 1'b1;
    #1;
    check("abort_busy", la_out, 0);
    check("abort_ack", {127'b0, ack}, 0);
    check("abort_dat", rdat, 0);
    check("abort_irq", user_irq, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_mem[600] = 5;
    check_dest("abort_dest", 600);
    do_op(0, 0, 100, 610);
    check_dest("post_reset_op", 610);

    // Random memory traffic, including random upper address bits
    for (int n = 0; n < 10; n++) begin
      logic [31:0] a = $urandom;
      logic [31:0] v = $urandom;
      if (a == OPC) a = a ^ 32'h1;
      wb_write(a, v);
      model_mem[a[9:0]] = v; model_valid[a[9:0]] = 1'b1;
      wb_read(a, r); check("rand_mem", r, v);
    end

    // Random operations
    for (int n = 0; n < 15; n++) begin
      int op = $urandom_range(0, 3);
      int a  = $urandom_range(0, Q - 1);
      int b  = $urandom_range(0, Q - 1);
      int d  = $urandom_range(0, Q - 1);
      for (int i = 0; i < NEL; i++) mem_write((a + i) % Q, $urandom);
      for (int i = 0; i < NEL; i++) mem_write((b + i) % Q, $urandom);
      do_op(op, a, b, d);
      check_dest("rand_op", d);
    end

    check("io_out", io_out, 0);
    check("io_oeb", io_oeb, {38{1'b1}});
    check("la_idle", la_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
